// File: rtl/bitcoin_hash_host.sv
// bitcoin_hash_host: host-side sequencer for the nonce-search hasher.
// Streams a block header into shared word memory, kicks the hasher, waits
// for completion, then scans the per-nonce H0 results for the minimum and
// reports it against an unsigned target.
module bitcoin_hash_host #(
  parameter int          NUM_NONCE = 16,
  parameter int          MSG_WORDS = 19,
  parameter logic [15:0] MSG_ADDR  = 16'h0000,
  parameter logic [15:0] OUT_ADDR  = 16'h0040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [31:0] hdr_data,
  input  logic [31:0] target,
  output logic        hash_start,
  input  logic        hash_done,
  output logic [15:0] hash_message_addr,
  output logic [15:0] hash_output_addr,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        result_valid,
  input  logic        result_ack,
  output logic        found,
  output logic [3:0]  best_nonce,
  output logic [31:0] best_hash
);

  localparam int CW = $clog2(MSG_WORDS + 1);
  localparam int RW = $clog2(NUM_NONCE + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(MSG_WORDS - 1);
  localparam logic [RW-1:0] LAST_RD   = RW'(NUM_NONCE);

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_KICK   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_READ   = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] count_r;
  logic [RW-1:0] rd_cnt_r;
  logic [31:0]   best_hash_r, best_hash_s;
  logic [3:0]    best_nonce_r, best_nonce_s;
  logic          found_r;
  logic [31:0]   target_r;
  logic          hs_s;

  assign hash_message_addr = MSG_ADDR;
  assign hash_output_addr  = OUT_ADDR;
  assign best_hash         = best_hash_r;
  assign best_nonce        = best_nonce_r;
  assign found             = found_r;

  // A header word is accepted only in LOAD and never while reset is asserted.
  assign hs_s = (state_r == ST_LOAD) && hdr_valid && !reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and memory-port / handshake outputs.
  always_comb begin
    state_s        = state_r;
    hdr_ready      = 1'b0;
    hash_start     = 1'b0;
    mem_sel        = 1'b1;
    mem_we         = 1'b0;
    mem_addr       = MSG_ADDR;
    mem_write_data = 32'h0000_0000;
    result_valid   = 1'b0;
    case (state_r)
      ST_LOAD: begin
        hdr_ready = !reset;
        mem_addr  = MSG_ADDR + 16'(count_r);
        if (hs_s) begin
          mem_we         = 1'b1;
          mem_write_data = hdr_data;
          if (count_r == LAST_WORD) begin
            state_s = ST_KICK;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          mem_we = 1'b0;
        end
      end
      ST_KICK: begin
        mem_sel    = 1'b0;
        hash_start = 1'b1;
        state_s    = ST_WAIT;
      end
      ST_WAIT: begin
        mem_sel = 1'b0;
        if (hash_done) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_READ: begin
        // The terminal count cycle only captures; its address is never used.
        mem_addr = OUT_ADDR + 16'(rd_cnt_r);
        if (rd_cnt_r == LAST_RD) begin
          state_s = ST_REPORT;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_REPORT: begin
        result_valid = 1'b1;
        if (result_ack) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_REPORT;
        end
      end
      default: begin
        state_s = ST_LOAD;
      end
    endcase
  end

  // Running minimum: data for index r arrives while rd_cnt_r is r+1; strict
  // less-than keeps the lowest nonce on ties.
  always_comb begin
    best_hash_s  = best_hash_r;
    best_nonce_s = best_nonce_r;
    if ((state_r == ST_READ) && (rd_cnt_r != {RW{1'b0}}) && (mem_read_data < best_hash_r)) begin
      best_hash_s  = mem_read_data;
      best_nonce_s = 4'(rd_cnt_r - RW'(1));
    end else begin
      best_hash_s  = best_hash_r;
      best_nonce_s = best_nonce_r;
    end
  end

  // Header counter, read counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r      <= {CW{1'b0}};
      rd_cnt_r     <= {RW{1'b0}};
      best_hash_r  <= 32'hFFFF_FFFF;
      best_nonce_r <= 4'd0;
      found_r      <= 1'b0;
      target_r     <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (hs_s) begin
            count_r <= count_r + CW'(1);
          end else begin
            count_r <= count_r;
          end
        end
        ST_KICK: begin
          count_r <= {CW{1'b0}};
        end
        ST_WAIT: begin
          if (hash_done) begin
            rd_cnt_r     <= {RW{1'b0}};
            best_hash_r  <= 32'hFFFF_FFFF;
            best_nonce_r <= 4'd0;
            found_r      <= 1'b0;
            target_r     <= target;
          end else begin
            rd_cnt_r <= rd_cnt_r;
          end
        end
        ST_READ: begin
          rd_cnt_r     <= rd_cnt_r + RW'(1);
          best_hash_r  <= best_hash_s;
          best_nonce_r <= best_nonce_s;
          if (rd_cnt_r == LAST_RD) begin
            found_r <= (best_hash_s < target_r);
          end else begin
            found_r <= found_r;
          end
        end
        ST_REPORT: begin
          count_r <= {CW{1'b0}};
        end
        default: begin
          count_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule
